shop: RTL and testbench

Single-clock command processor for a small store database: accepts one ASCII-encoded command per `i_rdy` strobe, tracks registered users, the logged-in session and the item stock count, and returns an ASCII status word. It is the top-level transaction engine of the store design; a host or testbench drives commands and reads `o_a`.

---
 rtl/shop_pkg.sv | 62 ++++++
 rtl/shop_cmd_decode.sv | 29 ++
 rtl/shop.sv | 139 +++++++++++++
 tb/tb_shop.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shop_pkg.sv
// rtl/shop_pkg.sv - shared widths, ASCII key/response constants and command enum for shop
// Optional feature macro: SHOP_STATUS_EN (adds the "Status" command and its decimal formatter).
package shop_pkg;

   localparam int I_A_NUM_ASCII_CHARS = 7;
   localparam int O_A_NUM_ASCII_CHARS = 9;
   localparam int I_U_NUM_BITS        = 4;
   localparam int MAX_USERS           = 5;
   localparam int MAX_STOCK           = 15;

   localparam int I_A_W      = I_A_NUM_ASCII_CHARS * 8;
   localparam int O_A_W      = O_A_NUM_ASCII_CHARS * 8;
   localparam int STOCK_W    = $clog2(MAX_STOCK + 1);
   localparam int USER_IDX_W = $clog2(MAX_USERS);
   // One bit wider than either operand so stock + quantity never wraps.
   localparam int SUM_W      = ((I_U_NUM_BITS > STOCK_W) ? I_U_NUM_BITS : STOCK_W) + 1;

   // Command keys, right-justified and zero-padded to the command field width.
   localparam logic [I_A_W-1:0] KEY_LOGOUT  = {8'h00,  "Logout"};
   localparam logic [I_A_W-1:0] KEY_LOGIN   = {16'h00, "Login"};
   localparam logic [I_A_W-1:0] KEY_ADDUSR  = {8'h00,  "AddUsr"};
   localparam logic [I_A_W-1:0] KEY_DELUSR  = {8'h00,  "DelUsr"};
   localparam logic [I_A_W-1:0] KEY_ADDITEM = "AddItem";
   localparam logic [I_A_W-1:0] KEY_DELITEM = "DelItem";
   localparam logic [I_A_W-1:0] KEY_BUY     = {32'h00, "Buy"};
   localparam logic [I_A_W-1:0] KEY_NONE    = {24'h00, "NONE"};
   localparam logic [I_A_W-1:0] KEY_STATUS  = {8'h00,  "Status"};

   // Response words, right-justified and zero-padded to the response field width.
   localparam logic [O_A_W-1:0] RSP_OK       = {56'h00, "OK"};
   localparam logic [O_A_W-1:0] RSP_ERR_AUTH = {8'h00,  "ERR_AUTH"};
   localparam logic [O_A_W-1:0] RSP_ERR_USER = {8'h00,  "ERR_USER"};
   localparam logic [O_A_W-1:0] RSP_FULL     = {40'h00, "FULL"};
   localparam logic [O_A_W-1:0] RSP_EMPTY    = {32'h00, "EMPTY"};
   localparam logic [O_A_W-1:0] RSP_BAD_CMD  = {16'h00, "BAD_CMD"};
   localparam logic [O_A_W-1:0] RSP_IDLE     = {40'h00, "IDLE"};

   typedef enum logic [3:0] {
      CMD_NONE,
      CMD_LOGIN,
      CMD_LOGOUT,
      CMD_ADDUSR,
      CMD_DELUSR,
      CMD_ADDITEM,
      CMD_DELITEM,
      CMD_BUY,
      CMD_STATUS,
      CMD_BAD
   } cmd_e;

`ifdef SHOP_STATUS_EN
   // "STOCK=" followed by two decimal ASCII digits of the stock count.
   function automatic logic [O_A_W-1:0] status_str(input logic [STOCK_W-1:0] stock);
      logic [7:0] tens;
      logic [7:0] ones;
      tens = 8'h30 + 8'(stock / STOCK_W'(10));
      ones = 8'h30 + 8'(stock % STOCK_W'(10));
      return {8'h00, "STOCK=", tens, ones};
   endfunction
`endif

endpackage

// File: rtl/shop_cmd_decode.sv
// rtl/shop_cmd_decode.sv - combinational ASCII command key to command enum decoder
// Ports: i_key (right-justified ASCII key) -> o_cmd (command enum, CMD_BAD when unknown).
// Optional feature macro: SHOP_STATUS_EN (recognise the "Status" key).
module shop_cmd_decode
   import shop_pkg::*;
(
   input  logic [I_A_W-1:0] i_key,
   output cmd_e             o_cmd
);

   always_comb begin
      o_cmd = CMD_BAD;
      case (i_key)
         KEY_LOGOUT:  o_cmd = CMD_LOGOUT;
         KEY_LOGIN:   o_cmd = CMD_LOGIN;
         KEY_ADDUSR:  o_cmd = CMD_ADDUSR;
         KEY_DELUSR:  o_cmd = CMD_DELUSR;
         KEY_ADDITEM: o_cmd = CMD_ADDITEM;
         KEY_DELITEM: o_cmd = CMD_DELITEM;
         KEY_BUY:     o_cmd = CMD_BUY;
         KEY_NONE:    o_cmd = CMD_NONE;
`ifdef SHOP_STATUS_EN
         KEY_STATUS:  o_cmd = CMD_STATUS;
`endif
         default:     o_cmd = CMD_BAD;
      endcase
   end

endmodule

// File: rtl/shop.sv
// rtl/shop.sv - store command processor: users, login session, stock count, ASCII status
// Ports: i_clk, i_reset (async active-low), i_rdy (command strobe, rising edge),
//        i_u (id or quantity), i_a (ASCII command key), o_a (ASCII response, registered).
// Optional feature macro: SHOP_STATUS_EN (adds the "Status" command).
module shop
   import shop_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_rdy,
   input  logic [I_U_NUM_BITS-1:0] i_u,
   input  logic [I_A_W-1:0]        i_a,
   output logic [O_A_W-1:0]        o_a
);

   cmd_e cmd;

   logic                    rdy_prev_q, rdy_prev_d;
   logic [MAX_USERS-1:0]    users_q, users_d;
   logic                    logged_q, logged_d;
   logic [I_U_NUM_BITS-1:0] uid_q, uid_d;
   logic [STOCK_W-1:0]      stock_q, stock_d;
   logic [O_A_W-1:0]        o_a_q, o_a_d;

   logic             go;
   logic             is_admin;
   logic             is_user;
   logic             uid_ok;
   logic             user_valid;
   logic [SUM_W-1:0] sum_add;
   logic             qty_fits;
   logic             qty_le_stock;

   shop_cmd_decode u_decode (
      .i_key (i_a),
      .o_cmd (cmd)
   );

   assign go           = i_rdy && !rdy_prev_q;
   assign is_admin     = logged_q && (uid_q == '0);
   assign is_user      = logged_q && (uid_q != '0);
   assign uid_ok       = int'(i_u) < MAX_USERS;
   // Out-of-range ids are masked by uid_ok before the vector bit is trusted.
   assign user_valid   = uid_ok && users_q[USER_IDX_W'(i_u)];
   assign sum_add      = SUM_W'(stock_q) + SUM_W'(i_u);
   assign qty_fits     = sum_add <= SUM_W'(MAX_STOCK);
   assign qty_le_stock = SUM_W'(i_u) <= SUM_W'(stock_q);

   always_comb begin
      rdy_prev_d = i_rdy;
      users_d    = users_q;
      logged_d   = logged_q;
      uid_d      = uid_q;
      stock_d    = stock_q;
      o_a_d      = o_a_q;
      if (go) begin
         case (cmd)
            CMD_LOGIN: begin
               if (logged_q) begin
                  o_a_d = RSP_ERR_AUTH;
               end else if (user_valid) begin
                  logged_d = 1'b1;
                  uid_d    = i_u;
                  o_a_d    = RSP_OK;
               end else begin
                  o_a_d = RSP_ERR_USER;
               end
            end
            CMD_LOGOUT: begin
               if (logged_q) begin
                  logged_d = 1'b0;
                  o_a_d    = RSP_OK;
               end else begin
                  o_a_d = RSP_ERR_AUTH;
               end
            end
            CMD_ADDUSR, CMD_DELUSR: begin
               if (!is_admin) begin
                  o_a_d = RSP_ERR_AUTH;
               end else if (uid_ok && (i_u != '0) && (user_valid == (cmd == CMD_DELUSR))) begin
                  users_d[USER_IDX_W'(i_u)] = (cmd == CMD_ADDUSR);
                  o_a_d = RSP_OK;
               end else begin
                  o_a_d = RSP_ERR_USER;
               end
            end
            CMD_ADDITEM: begin
               if (!is_admin) begin
                  o_a_d = RSP_ERR_AUTH;
               end else if (qty_fits) begin
                  stock_d = STOCK_W'(sum_add);
                  o_a_d   = RSP_OK;
               end else begin
                  o_a_d = RSP_FULL;
               end
            end
            CMD_DELITEM, CMD_BUY: begin
               // DelItem is the admin's removal path; Buy is the same removal for customers.
               if ((cmd == CMD_DELITEM) ? !is_admin : !is_user) begin
                  o_a_d = RSP_ERR_AUTH;
               end else if (qty_le_stock) begin
                  stock_d = stock_q - STOCK_W'(i_u);
                  o_a_d   = RSP_OK;
               end else begin
                  o_a_d = RSP_EMPTY;
               end
            end
            CMD_NONE: o_a_d = RSP_IDLE;
`ifdef SHOP_STATUS_EN
            CMD_STATUS: o_a_d = logged_q ? status_str(stock_q) : RSP_ERR_AUTH;
`endif
            default: o_a_d = RSP_BAD_CMD;
         endcase
      end
      users_d[0] = 1'b1;
   end

   // Previous-strobe register resets to 1 so a strobe held across reset release is ignored.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rdy_prev_q <= 1'b1;
         users_q    <= MAX_USERS'(1);
         logged_q   <= 1'b0;
         uid_q      <= '0;
         stock_q    <= '0;
         o_a_q      <= RSP_IDLE;
      end else begin
         rdy_prev_q <= rdy_prev_d;
         users_q    <= users_d;
         logged_q   <= logged_d;
         uid_q      <= uid_d;
         stock_q    <= stock_d;
         o_a_q      <= o_a_d;
      end
   end

   assign o_a = o_a_q;

endmodule

// File: tb/tb_shop.sv
// tb/tb_shop.sv - self-checking bench for shop with a behavioural store model
module tb_shop;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_rdy;
   logic [3:0]  i_u;
   logic [55:0] i_a;
   logic [71:0] o_a;

   int n_checks = 0;
   int n_errors = 0;

   bit    m_users[5];
   bit    m_logged;
   int    m_uid;
   int    m_stock;
   string m_resp;

   string status_plan;

   string cmds[12] = '{"Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem",
                       "Buy", "NONE", "Status", "hi", "Login", "Buy"};

   shop dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_rdy   (i_rdy),
      .i_u     (i_u),
      .i_a     (i_a),
      .o_a     (o_a)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [55:0] key_vec(input string s);
      logic [55:0] v = '0;
      for (int i = 0; i < s.len(); i++) v = {v[47:0], s[i]};
      return v;
   endfunction

   function automatic logic [71:0] resp_vec(input string s);
      logic [71:0] v = '0;
      for (int i = 0; i < s.len(); i++) v = {v[63:0], s[i]};
      return v;
   endfunction

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      foreach (m_users[i]) m_users[i] = 1'b0;
      m_users[0] = 1'b1;
      m_logged   = 1'b0;
      m_uid      = 0;
      m_stock    = 0;
      m_resp     = "IDLE";
   endtask

   task automatic m_exec(input string c, input int u);
      bit admin;
      bit valid;
      admin = m_logged && (m_uid == 0);
      valid = (u < 5) && m_users[u % 5];
      if (c == "Login") begin
         if (m_logged) m_resp = "ERR_AUTH";
         else if (valid) begin m_logged = 1; m_uid = u; m_resp = "OK"; end
         else m_resp = "ERR_USER";
      end else if (c == "Logout") begin
         if (m_logged) begin m_logged = 0; m_resp = "OK"; end
         else m_resp = "ERR_AUTH";
      end else if (c == "AddUsr" || c == "DelUsr") begin
         if (!admin) m_resp = "ERR_AUTH";
         else if (u >= 1 && u < 5 && (valid == (c == "DelUsr"))) begin
            m_users[u] = (c == "AddUsr");
            m_resp = "OK";
         end else m_resp = "ERR_USER";
      end else if (c == "AddItem") begin
         if (!admin) m_resp = "ERR_AUTH";
         else if (m_stock + u <= 15) begin m_stock += u; m_resp = "OK"; end
         else m_resp = "FULL";
      end else if (c == "DelItem" || c == "Buy") begin
         if ((c == "DelItem") ? !admin : !(m_logged && m_uid != 0)) m_resp = "ERR_AUTH";
         else if (u <= m_stock) begin m_stock -= u; m_resp = "OK"; end
         else m_resp = "EMPTY";
      end else if (c == "NONE") begin
         m_resp = "IDLE";
`ifdef SHOP_STATUS_EN
      end else if (c == "Status") begin
         m_resp = m_logged ? $sformatf("STOCK=%02d", m_stock) : "ERR_AUTH";
`endif
      end else begin
         m_resp = "BAD_CMD";
      end
   endtask

   // Entered and left on a falling edge with the strobe low and its history cleared.
   task automatic issue(input string c, input int u, input string plan);
      i_a   = key_vec(c);
      i_u   = 4'(u);
      i_rdy = 1'b1;
      @(negedge i_clk);
      m_exec(c, u);
      check($sformatf("%s %0d model", c, u), o_a, resp_vec(m_resp));
      if (plan != "") check($sformatf("%s %0d plan", c, u), o_a, resp_vec(plan));
      i_rdy = 1'b0;
      @(negedge i_clk);
   endtask

   initial begin
      i_reset = 1'b0;
      i_rdy   = 1'b0;
      i_a     = '0;
      i_u     = '0;
      m_reset();
      repeat (3) @(negedge i_clk);
      check("reset o_a", o_a, resp_vec("IDLE"));
      i_reset = 1'b1;
      @(negedge i_clk);

      issue("Login", 4, "ERR_USER");
      issue("Login", 0, "OK");
      issue("AddItem", 5, "OK");
      issue("AddUsr", 3, "OK");
      issue("AddUsr", 3, "ERR_USER");
      issue("AddUsr", 7, "ERR_USER");
      issue("Logout", 0, "OK");
      issue("Login", 3, "OK");
      issue("Buy", 2, "OK");
      issue("Buy", 4, "EMPTY");
      issue("AddItem", 1, "ERR_AUTH");
      issue("Login", 0, "ERR_AUTH");
      issue("hi", 0, "BAD_CMD");
      issue("Buy", 3, "OK");
      issue("Buy", 0, "OK");
      issue("Logout", 0, "OK");
      issue("Logout", 0, "ERR_AUTH");
      issue("Login", 0, "OK");
      issue("AddItem", 3, "OK");
      issue("AddItem", 15, "FULL");
      issue("AddItem", 12, "OK");
      issue("AddItem", 1, "FULL");
      issue("DelItem", 15, "OK");
      issue("DelItem", 1, "EMPTY");
      issue("DelUsr", 0, "ERR_USER");
      issue("NONE", 0, "IDLE");
      issue("AddItem", 7, "OK");
`ifdef SHOP_STATUS_EN
      status_plan = "STOCK=07";
`else
      status_plan = "BAD_CMD";
`endif
      issue("Status", 0, status_plan);

      // Strobe held high for five cycles must add exactly one item.
      i_a   = key_vec("AddItem");
      i_u   = 4'd1;
      i_rdy = 1'b1;
      repeat (5) @(negedge i_clk);
      m_exec("AddItem", 1);
      check("held strobe o_a", o_a, resp_vec("OK"));
      i_rdy = 1'b0;
      @(negedge i_clk);
      issue("DelItem", 9, "EMPTY");
      issue("AddItem", 1, "OK");
      issue("DelItem", 9, "OK");
      issue("AddItem", 9, "OK");

      // Mid-stream reset with the strobe held across release.
      i_a     = key_vec("AddItem");
      i_u     = 4'd1;
      i_rdy   = 1'b1;
      i_reset = 1'b0;
      #1;
      check("async reset o_a", o_a, resp_vec("IDLE"));
      @(negedge i_clk);
      i_reset = 1'b1;
      m_reset();
      repeat (3) @(negedge i_clk);
      check("held across reset", o_a, resp_vec("IDLE"));
      i_rdy = 1'b0;
      @(negedge i_clk);
      issue("Login", 0, "OK");
      issue("DelItem", 1, "EMPTY");
      issue("Login", 3, "ERR_AUTH");
      issue("Logout", 0, "OK");
      issue("Login", 3, "ERR_USER");

      for (int k = 0; k < 400; k++) begin
         string c;
         int    u;
         c = cmds[$urandom_range(0, 11)];
         u = (c == "Login" || c == "AddUsr" || c == "DelUsr") ? $urandom_range(0, 6)
                                                              : $urandom_range(0, 15);
         issue(c, u, "");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
